// File: rtl/riscv_tag_policy_ctrl_pkg.sv
// Shared types and constants for the DIFT tag-policy sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package riscv_tag_policy_ctrl_pkg;

    // Update sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } tag_pol_state_t;

    // The TCR bit that freezes both policy registers until reset
    localparam int TCR_LOCK_BIT = 31;

    // Default CSR addresses of the policy registers
    localparam logic [11:0] CSR_TPR_ADDR = 12'h7C0;
    localparam logic [11:0] CSR_TCR_ADDR = 12'h7C1;

    // Index of each register in the staged/active pair arrays
    localparam int POL_TPR = 0;
    localparam int POL_TCR = 1;
    localparam int POL_NUM = 2;

endpackage

// File: rtl/riscv_tag_policy_ctrl.sv
// Stages TPR/TCR CSR writes, halts ID, drains the pipe, then commits atomically.
// Latency: write in cycle t is active from t+DRAIN_CYCLES+2 when the pipe is idle.
// Backpressure: halt_id_o holds ID while an update is pending; busy pipe restarts the drain.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   csr_we_i/addr/wdata single-cycle CSR write; csr_rdata_o reads staged-or-active value
//   pipe_busy_i         valid instruction in EX or WB
//   halt_id_o, busy_o   update pending (state != IDLE)
//   tpr_o, tcr_o        active policy registers
//   commit_o            one-cycle pulse in COMMIT; tpr_gen_o counts commits (mod 16)
//   csr_err_o           one-cycle pulse when a policy write is rejected by the lock
module riscv_tag_policy_ctrl
    import riscv_tag_policy_ctrl_pkg::*;
#(
    parameter logic [11:0] TPR_ADDR     = CSR_TPR_ADDR,
    parameter logic [11:0] TCR_ADDR     = CSR_TCR_ADDR,
    parameter logic [31:0] TPR_RESET    = 32'h0,
    parameter logic [31:0] TCR_RESET    = 32'h0,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    input  logic        pipe_busy_i,
    output logic        halt_id_o,
    output logic [31:0] tpr_o,
    output logic [31:0] tcr_o,
    output logic        commit_o,
    output logic [3:0]  tpr_gen_o,
    output logic        csr_err_o,
    output logic        busy_o
);

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    tag_pol_state_t state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     gen_q;

    logic [POL_NUM-1:0]       wr_hit;
    logic [POL_NUM-1:0]       wr_acc;
    logic [POL_NUM-1:0]       dirty_v;
    logic [POL_NUM-1:0][31:0] stg_v;
    logic [POL_NUM-1:0][31:0] act_v;

    logic lock;
    logic accept;
    logic in_commit;

    // Lock is taken from the active TCR only, so a write landing in the same
    // cycle a lock commits still sees the pre-commit value and is accepted.
    assign lock              = act_v[POL_TCR][TCR_LOCK_BIT];
    assign wr_hit[POL_TPR]   = csr_we_i && (csr_addr_i == TPR_ADDR);
    assign wr_hit[POL_TCR]   = csr_we_i && (csr_addr_i == TCR_ADDR);
    assign accept            = (|wr_hit) && !lock;
    assign wr_acc            = lock ? '0 : wr_hit;
    assign csr_err_o         = (|wr_hit) && lock;
    assign in_commit         = (state_q == COMMIT);

    // Staged/active register pair with dirty bit, one per policy register.
    for (genvar g = 0; g < POL_NUM; g++) begin : g_pol
        localparam logic [31:0] RST_VAL = (g == POL_TPR) ? TPR_RESET : TCR_RESET;

        logic [31:0] stg_q;
        logic [31:0] act_q;
        logic        dirty_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stg_q   <= RST_VAL;
                act_q   <= RST_VAL;
                dirty_q <= 1'b0;
            end else begin
                // Commit copies the staged value as it stood at the start of the cycle
                if (in_commit && dirty_q) begin
                    act_q <= stg_q;
                end
                // A write in the commit cycle re-dirties the register (set beats clear)
                if (wr_acc[g]) begin
                    stg_q   <= csr_wdata_i;
                    dirty_q <= 1'b1;
                end else if (in_commit) begin
                    dirty_q <= 1'b0;
                end
            end
        end

        assign stg_v[g]   = stg_q;
        assign act_v[g]   = act_q;
        assign dirty_v[g] = dirty_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            gen_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_commit) begin
                gen_q <= gen_q + 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DRAIN;
                    cnt_d   = 4'd0;
                end
            end
            DRAIN: begin
                // A new write restarts the drain and overrides a pending commit
                if (accept || pipe_busy_i) begin
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (accept) begin
                    state_d = DRAIN;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy_o    = (state_q != IDLE);
        halt_id_o = (state_q != IDLE);
        commit_o  = in_commit;
        tpr_o     = act_v[POL_TPR];
        tcr_o     = act_v[POL_TCR];
        tpr_gen_o = gen_q;
    end

    // Readback shows the pending value while one is staged
    always_comb begin
        csr_rdata_o = 32'h0;
        if (csr_addr_i == TPR_ADDR) begin
            csr_rdata_o = dirty_v[POL_TPR] ? stg_v[POL_TPR] : act_v[POL_TPR];
        end else if (csr_addr_i == TCR_ADDR) begin
            csr_rdata_o = dirty_v[POL_TCR] ? stg_v[POL_TCR] : act_v[POL_TCR];
        end
    end

endmodule

// File: tb/tb_riscv_tag_policy_ctrl.sv
// Self-checking bench for riscv_tag_policy_ctrl (DRAIN_CYCLES = 2).
// Latency: n/a.
// Backpressure: pipe_busy_i driven from the stimulus.
module tb_riscv_tag_policy_ctrl;

    localparam logic [11:0] A_TPR = 12'h7C0;
    localparam logic [11:0] A_TCR = 12'h7C1;
    localparam logic [11:0] A_OTH = 12'h300;

    logic        clk;
    logic        rst_n;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        pipe_busy_i;
    logic        halt_id_o;
    logic [31:0] tpr_o;
    logic [31:0] tcr_o;
    logic        commit_o;
    logic [3:0]  tpr_gen_o;
    logic        csr_err_o;
    logic        busy_o;

    riscv_tag_policy_ctrl #(
        .TPR_ADDR     (A_TPR),
        .TCR_ADDR     (A_TCR),
        .TPR_RESET    (32'h0),
        .TCR_RESET    (32'h0),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_we_i    (csr_we_i),
        .csr_addr_i  (csr_addr_i),
        .csr_wdata_i (csr_wdata_i),
        .csr_rdata_o (csr_rdata_o),
        .pipe_busy_i (pipe_busy_i),
        .halt_id_o   (halt_id_o),
        .tpr_o       (tpr_o),
        .tcr_o       (tcr_o),
        .commit_o    (commit_o),
        .tpr_gen_o   (tpr_gen_o),
        .csr_err_o   (csr_err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] tpr;
        logic [31:0] tcr;
        logic [3:0]  gen;
    } sb_t;

    sb_t exp_q[$];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        e_halt;
        logic        e_commit;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_tpr;
        logic [31:0] e_tcr;
        logic [3:0]  e_gen;
        logic        sb;
        logic [31:0] sb_tpr;
        logic [31:0] sb_tcr;
        logic [3:0]  sb_gen;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                input logic busy, input logic e_halt, input logic e_commit,
                                input logic e_err, input logic [31:0] e_rdata, input logic [31:0] e_tpr,
                                input logic [31:0] e_tcr, input logic [3:0] e_gen, input logic sb,
                                input logic [31:0] sb_tpr, input logic [31:0] sb_tcr, input logic [3:0] sb_gen);
        vec_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.busy = busy;
        r.e_halt = e_halt; r.e_commit = e_commit; r.e_err = e_err; r.e_rdata = e_rdata;
        r.e_tpr = e_tpr; r.e_tcr = e_tcr; r.e_gen = e_gen;
        r.sb = sb; r.sb_tpr = sb_tpr; r.sb_tcr = sb_tcr; r.sb_gen = sb_gen;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] t, input logic [31:0] c, input logic [3:0] g);
        sb_t e;
        e.tpr = t; e.tcr = c; e.gen = g;
        exp_q.push_back(e);
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge for sampling
    task automatic apply(input logic we, input logic [11:0] a, input logic [31:0] d, input logic b);
        @(posedge clk);
        #1;
        csr_we_i    = we;
        csr_addr_i  = a;
        csr_wdata_i = d;
        pipe_busy_i = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, A_TPR, 32'h0, 1'b0);
    endtask

    // Scoreboard monitor: the cycle after each commit pulse the active registers
    // must equal the next queued expectation; a commit with nothing queued is spurious.
    logic commit_seen = 1'b0;
    always @(negedge clk) begin
        if (commit_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_spurious_commit: got commit with tpr_o=0x%08h, expected no commit at %0t", tpr_o, $time);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                chk("sb_tpr", tpr_o, e.tpr);
                chk("sb_tcr", tcr_o, e.tcr);
                chk("sb_gen", 32'(tpr_gen_o), 32'(e.gen));
            end
        end
        commit_seen = commit_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] g;

    initial begin
        rst_n       = 1'b0;
        csr_we_i    = 1'b0;
        csr_addr_i  = A_TPR;
        csr_wdata_i = 32'h0;
        pipe_busy_i = 1'b0;

        // Basic write/commit timing, other-address write, restart on write during DRAIN
        //              we    addr   wdata         bsy halt cmt err rdata         tpr           tcr   gen sb  sb_tpr        sb_tcr sb_gen
        tbl[0]  = mk(1'b0, A_TPR, 32'h0,         0,  0,  0,  0, 32'h0,        32'h0,        32'h0, 0, 0, 32'h0,        32'h0, 0);
        tbl[1]  = mk(1'b1, A_TPR, 32'hA5A5_0001, 0,  0,  0,  0, 32'h0,        32'h0,        32'h0, 0, 1, 32'hA5A5_0001, 32'h0, 1);
        tbl[2]  = mk(1'b0, A_TPR, 32'h0,         0,  1,  0,  0, 32'hA5A5_0001, 32'h0,       32'h0, 0, 0, 32'h0,        32'h0, 0);
        tbl[3]  = mk(1'b0, A_TPR, 32'h0,         0,  1,  0,  0, 32'hA5A5_0001, 32'h0,       32'h0, 0, 0, 32'h0,        32'h0, 0);
        tbl[4]  = mk(1'b0, A_TPR, 32'h0,         0,  1,  1,  0, 32'hA5A5_0001, 32'h0,       32'h0, 0, 0, 32'h0,        32'h0, 0);
        tbl[5]  = mk(1'b0, A_TPR, 32'h0,         0,  0,  0,  0, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0, 1, 0, 32'h0,      32'h0, 0);
        tbl[6]  = mk(1'b0, A_TCR, 32'h0,         0,  0,  0,  0, 32'h0,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[7]  = mk(1'b1, A_OTH, 32'hFFFF_FFFF, 0,  0,  0,  0, 32'h0,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[8]  = mk(1'b0, A_TPR, 32'h0,         0,  0,  0,  0, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0, 1, 0, 32'h0,      32'h0, 0);
        tbl[9]  = mk(1'b1, A_TPR, 32'h1,         0,  0,  0,  0, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0, 1, 1, 32'h2,      32'h0, 2);
        tbl[10] = mk(1'b0, A_TPR, 32'h0,         0,  1,  0,  0, 32'h1,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[11] = mk(1'b1, A_TPR, 32'h2,         0,  1,  0,  0, 32'h1,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[12] = mk(1'b0, A_TPR, 32'h0,         0,  1,  0,  0, 32'h2,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[13] = mk(1'b0, A_TPR, 32'h0,         0,  1,  0,  0, 32'h2,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[14] = mk(1'b0, A_TPR, 32'h0,         0,  1,  1,  0, 32'h2,        32'hA5A5_0001, 32'h0, 1, 0, 32'h0,       32'h0, 0);
        tbl[15] = mk(1'b0, A_TPR, 32'h0,         0,  0,  0,  0, 32'h2,        32'h2,        32'h0, 2, 0, 32'h0,        32'h0, 0);

        #12;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].busy);
            if (tbl[i].sb) push(tbl[i].sb_tpr, tbl[i].sb_tcr, tbl[i].sb_gen);
            chk($sformatf("tbl%0d_halt", i),   32'(halt_id_o), 32'(tbl[i].e_halt));
            chk($sformatf("tbl%0d_busy", i),   32'(busy_o),    32'(tbl[i].e_halt));
            chk($sformatf("tbl%0d_commit", i), 32'(commit_o),  32'(tbl[i].e_commit));
            chk($sformatf("tbl%0d_err", i),    32'(csr_err_o), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rdata", i),  csr_rdata_o,    tbl[i].e_rdata);
            chk($sformatf("tbl%0d_tpr", i),    tpr_o,          tbl[i].e_tpr);
            chk($sformatf("tbl%0d_tcr", i),    tcr_o,          tbl[i].e_tcr);
            chk($sformatf("tbl%0d_gen", i),    32'(tpr_gen_o), 32'(tbl[i].e_gen));
        end

        // Busy pipe holds the drain: busy t+1..t+5, commit at t+8, new value at t+9
        apply(1'b1, A_TPR, 32'h11, 1'b0);
        push(32'h11, 32'h0, 4'd3);
        for (int k = 1; k <= 9; k++) begin
            apply(1'b0, A_TPR, 32'h0, (k <= 5));
            chk($sformatf("busy_seq_commit_t%0d", k), 32'(commit_o), 32'(k == 8));
            chk($sformatf("busy_seq_halt_t%0d", k),   32'(halt_id_o), 32'(k <= 8));
        end

        // Lock: commit TCR bit 31, then policy writes are rejected
        apply(1'b1, A_TCR, 32'h8000_0000, 1'b0);
        push(32'h11, 32'h8000_0000, 4'd4);
        idle(4);
        chk("lock_tcr", tcr_o, 32'h8000_0000);
        apply(1'b1, A_TPR, 32'h5, 1'b0);
        chk("lock_err_tpr", 32'(csr_err_o), 32'd1);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("lock_err_clear", 32'(csr_err_o), 32'd0);
        chk("lock_busy", 32'(busy_o), 32'd0);
        chk("lock_tpr", tpr_o, 32'h11);
        chk("lock_rdata", csr_rdata_o, 32'h11);
        apply(1'b1, A_TCR, 32'h0, 1'b0);
        chk("lock_err_tcr", 32'(csr_err_o), 32'd1);
        apply(1'b1, A_OTH, 32'h1234, 1'b0);
        chk("lock_err_other", 32'(csr_err_o), 32'd0);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("lock_busy2", 32'(busy_o), 32'd0);
        chk("lock_tcr_kept", tcr_o, 32'h8000_0000);

        // Reset pulse clears the lock
        rst_n = 1'b0;
        #1;
        chk("rst_tcr", tcr_o, 32'h0);
        chk("rst_tpr", tpr_o, 32'h0);
        chk("rst_gen", 32'(tpr_gen_o), 32'd0);
        #1;
        rst_n = 1'b1;

        // Write in the COMMIT cycle: first commit takes 3, second takes 7
        apply(1'b1, A_TPR, 32'h3, 1'b0);
        chk("coll_err", 32'(csr_err_o), 32'd0);
        push(32'h3, 32'h0, 4'd1);
        push(32'h7, 32'h0, 4'd2);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("coll_busy_t1", 32'(busy_o), 32'd1);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        apply(1'b1, A_TPR, 32'h7, 1'b0);
        chk("coll_commit_t3", 32'(commit_o), 32'd1);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("coll_redrain_t4", 32'(busy_o), 32'd1);
        chk("coll_tpr_t4", tpr_o, 32'h3);
        chk("coll_rdata_t4", csr_rdata_o, 32'h7);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("coll_commit_t6", 32'(commit_o), 32'd1);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("coll_idle_t7", 32'(busy_o), 32'd0);
        chk("coll_tpr_t7", tpr_o, 32'h7);
        chk("coll_gen_t7", 32'(tpr_gen_o), 32'd2);

        // Sixteen commits: generation wraps 15 -> 0 and returns to its start value
        g = 4'd2;
        for (int i = 0; i < 16; i++) begin
            g = g + 4'd1;
            apply(1'b1, A_TPR, 32'h100 + 32'(i), 1'b0);
            push(32'h100 + 32'(i), 32'h0, g);
            idle(4);
        end
        chk("wrap_gen", 32'(tpr_gen_o), 32'd2);

        // Reset during DRAIN: halt drops immediately and the pending value is lost
        apply(1'b1, A_TPR, 32'hDEAD, 1'b0);
        apply(1'b0, A_TPR, 32'h0, 1'b0);
        chk("rstdrain_halt_before", 32'(halt_id_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstdrain_halt_async", 32'(halt_id_o), 32'd0);
        chk("rstdrain_busy_async", 32'(busy_o), 32'd0);
        chk("rstdrain_tpr_async", tpr_o, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, A_TPR, 32'h0, 1'b0);
            chk($sformatf("rstdrain_no_commit%0d", k), 32'(commit_o), 32'd0);
        end
        chk("rstdrain_tpr", tpr_o, 32'h0);
        chk("rstdrain_rdata", csr_rdata_o, 32'h0);
        chk("rstdrain_gen", 32'(tpr_gen_o), 32'd0);

        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
